// File: rtl/nsdp_checker_pkg.sv
// ============================================================================
// Module : nsdp_checker_pkg
// Brief  : Shared error-bit indices, state encoding and defaults for the
//          NSDP per-channel packet checker.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package nsdp_checker_pkg;

  localparam int ERR_WIDTH       = 9;
  localparam int ERR_SHORT       = 0;
  localparam int ERR_LONG        = 1;
  localparam int ERR_BAD_FDATA   = 2;
  localparam int ERR_BAD_PAYLOAD = 3;
  localparam int ERR_BAD_MAGIC   = 4;
  localparam int ERR_BAD_TKEEP   = 5;
  localparam int ERR_LINK_DROP   = 6;

  localparam logic [31:0] MAGIC_DEFAULT = 32'h4E534450;

  typedef enum logic [1:0] {
    HEADER  = 2'd0,
    PAYLOAD = 2'd1,
    ERROR   = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/nsdp_beat_compare.sv
// ============================================================================
// Module : nsdp_beat_compare
// Brief  : Combinational per-beat word/magic/keep comparison producing the
//          data-dependent subset of the error flags.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nsdp_beat_compare
  import nsdp_checker_pkg::*;
#(
  parameter logic [31:0] MAGIC = MAGIC_DEFAULT
) (
  input  logic [511:0]          i_tdata,
  input  logic [63:0]           i_tkeep,
  input  logic [31:0]           i_ref,
  input  logic                  i_is_header,
  input  logic                  i_check_fdata,
  output logic [ERR_WIDTH-1:0]  o_flags
);

  logic [15:0] w_word_ne;

  for (genvar k = 0; k < 16; k++) begin : g_word
    assign w_word_ne[k] = (i_tdata[32*k +: 32] != i_ref);
  end

  // Header beats only check word 0 (fdata) and word 1 (magic); payload beats check every word.
  always_comb begin
    o_flags                  = '0;
    o_flags[ERR_BAD_FDATA]   = i_is_header & i_check_fdata & w_word_ne[0];
    o_flags[ERR_BAD_PAYLOAD] = ~i_is_header & (|w_word_ne);
    o_flags[ERR_BAD_MAGIC]   = i_is_header & (i_tdata[63:32] != MAGIC);
    o_flags[ERR_BAD_TKEEP]   = (i_tkeep != {64{1'b1}});
  end

endmodule

`default_nettype wire

// File: rtl/nsdp_channel_checker.sv
// ============================================================================
// Module : nsdp_channel_checker
// Brief  : Per-channel NSDP packet checker; validates length, magic, fdata
//          sequence and payload, latching the first offending beat.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nsdp_channel_checker
  import nsdp_checker_pkg::*;
#(
  parameter int          PKT_BEATS = 128,
  parameter logic [31:0] MAGIC     = MAGIC_DEFAULT
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  link_up,
  input  logic                  clear,
  input  logic [511:0]          AXIS_RX_TDATA,
  input  logic [63:0]           AXIS_RX_TKEEP,
  input  logic                  AXIS_RX_TLAST,
  input  logic                  AXIS_RX_TVALID,
  output logic                  AXIS_RX_TREADY,
  output logic                  eth_active,
  output logic                  status,
  output logic [ERR_WIDTH-1:0]  error,
  output logic [511:0]          error_data,
  output logic [31:0]           expected_fdata
);

  localparam logic [15:0] c_PKT_BEATS = 16'(PKT_BEATS);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [15:0]            r_beat;
  logic [31:0]            r_fdata;
  logic                   r_seeded;
  logic                   r_eth_active;
  logic                   r_status;
  logic [ERR_WIDTH-1:0]   r_error;
  logic [511:0]           r_error_data;
  logic [31:0]            r_expected;

  logic                   w_is_header;
  logic [31:0]            w_ref;
  logic [15:0]            w_beat_num;
  logic [ERR_WIDTH-1:0]   w_cmp_flags;
  logic [ERR_WIDTH-1:0]   w_flags;
  logic                   w_err_hit;
  logic                   w_hdr_ok;
  logic                   w_done;

  assign AXIS_RX_TREADY = 1'b1;

  assign w_is_header = (r_state == HEADER);
  assign w_ref       = w_is_header ? r_expected : r_fdata;
  // The header is beat 1 (r_beat is 0 there); counting saturates at PKT_BEATS.
  assign w_beat_num  = (r_beat >= c_PKT_BEATS) ? c_PKT_BEATS : r_beat + 16'd1;

  nsdp_beat_compare #(
    .MAGIC (MAGIC)
  ) u_cmp (
    .i_tdata       (AXIS_RX_TDATA),
    .i_tkeep       (AXIS_RX_TKEEP),
    .i_ref         (w_ref),
    .i_is_header   (w_is_header),
    .i_check_fdata (r_seeded),
    .o_flags       (w_cmp_flags)
  );

  always_comb begin
    w_flags                = w_cmp_flags;
    w_flags[ERR_SHORT]     = AXIS_RX_TLAST & (w_beat_num < c_PKT_BEATS);
    w_flags[ERR_LONG]      = ~AXIS_RX_TLAST & (w_beat_num == c_PKT_BEATS);
    w_flags[ERR_LINK_DROP] = (r_state == PAYLOAD) & ~link_up;
  end

  assign w_err_hit = AXIS_RX_TVALID & (r_state != ERROR) & (|w_flags);
  assign w_hdr_ok  = AXIS_RX_TVALID & w_is_header & ~w_err_hit;
  assign w_done    = AXIS_RX_TVALID & (r_state == PAYLOAD) & ~w_err_hit & AXIS_RX_TLAST;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= HEADER;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clear)          w_state_nxt = HEADER;
    else if (w_err_hit) w_state_nxt = ERROR;
    else if (w_hdr_ok)  w_state_nxt = PAYLOAD;
    else if (w_done)    w_state_nxt = HEADER;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_eth_active <= 1'b0;
    else         r_eth_active <= link_up;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_beat       <= '0;
      r_fdata      <= '0;
      r_seeded     <= 1'b0;
      r_status     <= 1'b0;
      r_error      <= '0;
      r_error_data <= '0;
      r_expected   <= '0;
    end else if (clear) begin
      r_beat       <= '0;
      r_fdata      <= '0;
      r_seeded     <= 1'b0;
      r_status     <= 1'b0;
      r_error      <= '0;
      r_error_data <= '0;
      r_expected   <= '0;
    end else if (w_err_hit) begin
      r_error      <= w_flags;
      r_error_data <= AXIS_RX_TDATA;
      r_status     <= 1'b0;
    end else if (w_hdr_ok) begin
      r_fdata      <= AXIS_RX_TDATA[31:0];
      r_expected   <= AXIS_RX_TDATA[31:0] + 32'd1;
      r_seeded     <= 1'b1;
      r_beat       <= 16'd1;
    end else if (AXIS_RX_TVALID && (r_state == PAYLOAD)) begin
      if (w_done) begin
        r_beat   <= '0;
        r_status <= 1'b1;
      end else begin
        r_beat   <= w_beat_num;
      end
    end
  end

  assign eth_active     = r_eth_active;
  assign status         = r_status;
  assign error          = r_error;
  assign error_data     = r_error_data;
  assign expected_fdata = r_expected;

endmodule

`default_nettype wire
